// File: rtl/farmer_crossing_ctrl.sv
// Farmer/fox/goat/beans crossing sequencer: validates one move per handshake, commits safe legal moves.
// Optional FARMER_UNDO_EN adds a one-level undo of the last committed move.
module farmer_crossing_ctrl #(
    parameter int MAX_MOVES = 15,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             move_valid,
    input  logic [1:0]       move_sel,
`ifdef FARMER_UNDO_EN
    input  logic             undo_req,
`endif
    output logic             move_ready,
    output logic             f,
    output logic             x,
    output logic             g,
    output logic             b,
    output logic [CNT_W-1:0] moves,
    output logic             rej,
    output logic [1:0]       rej_code,
    output logic             done,
    output logic             exhausted
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_MOVES);

    typedef enum logic [2:0] {IDLE, CHECK, COMMIT, REJECT, WON, EXHAUSTED} state_t;

    state_t           state;
    logic [1:0]       sel_q;
    logic [1:0]       code_q;
    logic [3:0]       cand_q;
    logic [3:0]       pos;
    logic [3:0]       cand;
    logic             item_bank;
    logic             illegal;
    logic             unsafe;
    logic [CNT_W-1:0] moves_inc;
`ifdef FARMER_UNDO_EN
    logic [3:0]       snap;
    logic             snap_vld;
`endif

    // Fox eats goat, or goat eats beans, whenever the pair is left without the farmer.
    function automatic logic eaten(input logic [3:0] s);
        return ((s[3] ^ s[2]) & ~(s[2] ^ s[1])) | ((s[3] ^ s[1]) & ~(s[1] ^ s[0]));
    endfunction

    assign pos       = {f, x, g, b};
    assign moves_inc = moves + CNT_W'(1);

    always_comb begin
        cand      = pos ^ 4'b1000;
        item_bank = f;
        case (sel_q)
            2'd1: begin cand[2] = ~x; item_bank = x; end
            2'd2: begin cand[1] = ~g; item_bank = g; end
            2'd3: begin cand[0] = ~b; item_bank = b; end
            default: ;
        endcase
        illegal = (item_bank != f);
        unsafe  = eaten(cand);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sel_q      <= 2'b00;
            code_q     <= 2'b00;
            cand_q     <= 4'b0000;
            {f, x, g, b} <= 4'b0000;
            moves      <= '0;
            rej        <= 1'b0;
            rej_code   <= 2'b00;
            done       <= 1'b0;
            exhausted  <= 1'b0;
            move_ready <= 1'b1;
`ifdef FARMER_UNDO_EN
            snap       <= 4'b0000;
            snap_vld   <= 1'b0;
`endif
        end else begin
            rej <= 1'b0;
            case (state)
                IDLE: begin
                    if (move_valid) begin
                        sel_q      <= move_sel;
                        move_ready <= 1'b0;
                        state      <= CHECK;
                    end
`ifdef FARMER_UNDO_EN
                    else if (undo_req) begin
                        if (snap_vld && moves != '0) begin
                            {f, x, g, b} <= snap;
                            moves        <= moves - CNT_W'(1);
                            snap_vld     <= 1'b0;
                        end else begin
                            rej      <= 1'b1;
                            rej_code <= 2'b11;
                        end
                    end
`endif
                end
                CHECK: begin
                    cand_q <= cand;
                    // Illegal selection outranks the safety verdict.
                    if (illegal) begin
                        code_q <= 2'b01;
                        state  <= REJECT;
                    end else if (unsafe) begin
                        code_q <= 2'b10;
                        state  <= REJECT;
                    end else begin
                        state  <= COMMIT;
                    end
                end
                REJECT: begin
                    rej        <= 1'b1;
                    rej_code   <= code_q;
                    move_ready <= 1'b1;
                    state      <= IDLE;
                end
                COMMIT: begin
                    {f, x, g, b} <= cand_q;
                    if (moves != MAX_C)
                        moves <= moves_inc;
`ifdef FARMER_UNDO_EN
                    snap     <= pos;
                    snap_vld <= 1'b1;
`endif
                    if (cand_q == 4'b1111) begin
                        done  <= 1'b1;
                        state <= WON;
                    end else if (moves_inc == MAX_C) begin
                        exhausted <= 1'b1;
                        state     <= EXHAUSTED;
                    end else begin
                        move_ready <= 1'b1;
                        state      <= IDLE;
                    end
                end
                WON, EXHAUSTED: move_ready <= 1'b0;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_farmer_crossing_ctrl.sv
// Bench: two controllers (budget 15 and 4) on shared stimulus, compared every cycle against a puzzle-level model.
module tb_farmer_crossing_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       move_valid = 1'b0;
    logic [1:0] move_sel = 2'd0;
`ifdef FARMER_UNDO_EN
    logic       undo_req = 1'b0;
`endif
    logic [1:0] ready_o, f_o, x_o, g_o, b_o, rej_o, done_o, exh_o;
    logic [3:0] moves_o [2];
    logic [1:0] code_o  [2];

    always #5 clk = ~clk;

    farmer_crossing_ctrl #(.MAX_MOVES(15), .CNT_W(4)) u0 (
        .clk(clk), .reset(reset), .move_valid(move_valid), .move_sel(move_sel),
`ifdef FARMER_UNDO_EN
        .undo_req(undo_req),
`endif
        .move_ready(ready_o[0]), .f(f_o[0]), .x(x_o[0]), .g(g_o[0]), .b(b_o[0]),
        .moves(moves_o[0]), .rej(rej_o[0]), .rej_code(code_o[0]),
        .done(done_o[0]), .exhausted(exh_o[0]));

    farmer_crossing_ctrl #(.MAX_MOVES(4), .CNT_W(4)) u1 (
        .clk(clk), .reset(reset), .move_valid(move_valid), .move_sel(move_sel),
`ifdef FARMER_UNDO_EN
        .undo_req(undo_req),
`endif
        .move_ready(ready_o[1]), .f(f_o[1]), .x(x_o[1]), .g(g_o[1]), .b(b_o[1]),
        .moves(moves_o[1]), .rej(rej_o[1]), .rej_code(code_o[1]),
        .done(done_o[1]), .exhausted(exh_o[1]));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Model: bank[k][0..3] = farmer, fox, goat, beans; busy counts cycles left until a move resolves.
    int bank   [2][4];
    int snapb  [2][4];
    int snap_v [2];
    int mv [2], rj [2], cd [2], dn [2], ex [2], busy [2], psel [2];
    int maxm [2] = '{15, 4};
    bit cmp_en = 0;

    task automatic resolve(input int k);
        int nb [4];
        int s;
        s = psel[k];
        for (int i = 0; i < 4; i++) nb[i] = bank[k][i];
        nb[0] = 1 - nb[0];
        if (s != 0) nb[s] = 1 - nb[s];
        if (bank[k][s] != bank[k][0]) begin
            rj[k] = 1; cd[k] = 1;
        end else if ((nb[1] == nb[2] && nb[0] != nb[2]) || (nb[2] == nb[3] && nb[0] != nb[2])) begin
            rj[k] = 1; cd[k] = 2;
        end else begin
            for (int i = 0; i < 4; i++) begin
                snapb[k][i] = bank[k][i];
                bank[k][i]  = nb[i];
            end
            snap_v[k] = 1;
            mv[k]++;
            if (nb[0] + nb[1] + nb[2] + nb[3] == 4) dn[k] = 1;
            else if (mv[k] == maxm[k])              ex[k] = 1;
        end
    endtask

    task automatic model_step(input int k);
        if (reset) begin
            for (int i = 0; i < 4; i++) bank[k][i] = 0;
            snap_v[k] = 0; mv[k] = 0; rj[k] = 0; cd[k] = 0;
            dn[k] = 0; ex[k] = 0; busy[k] = 0; psel[k] = 0;
        end else begin
            rj[k] = 0;
            if (busy[k] == 2) busy[k] = 1;
            else if (busy[k] == 1) begin
                resolve(k);
                busy[k] = 0;
            end else if (dn[k] == 0 && ex[k] == 0) begin
                if (move_valid) begin
                    psel[k] = int'(move_sel);
                    busy[k] = 2;
                end
`ifdef FARMER_UNDO_EN
                else if (undo_req) begin
                    if (snap_v[k] == 1 && mv[k] > 0) begin
                        for (int i = 0; i < 4; i++) bank[k][i] = snapb[k][i];
                        mv[k]--;
                        snap_v[k] = 0;
                    end else begin
                        rj[k] = 1; cd[k] = 3;
                    end
                end
`endif
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("u%0d.pos", k), int'({f_o[k], x_o[k], g_o[k], b_o[k]}),
                      bank[k][0] * 8 + bank[k][1] * 4 + bank[k][2] * 2 + bank[k][3]);
                check($sformatf("u%0d.moves", k), int'(moves_o[k]), mv[k]);
                check($sformatf("u%0d.rej", k), int'(rej_o[k]), rj[k]);
                check($sformatf("u%0d.rej_code", k), int'(code_o[k]), cd[k]);
                check($sformatf("u%0d.done", k), int'(done_o[k]), dn[k]);
                check($sformatf("u%0d.exhausted", k), int'(exh_o[k]), ex[k]);
                check($sformatf("u%0d.move_ready", k), int'(ready_o[k]),
                      (busy[k] == 0 && dn[k] == 0 && ex[k] == 0) ? 1 : 0);
            end
        end
    end

    task automatic cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    // One handshake on u0, then wait for the outcome (visible two edges after acceptance).
    task automatic do_move(input int sel);
        int n = 0;
        while (!ready_o[0] && n < 20) begin
            cycle();
            n++;
        end
        if (n >= 20) check("handshake_timeout", 0, 1);
        move_valid = 1'b1;
        move_sel   = 2'(sel);
        cycle();
        move_valid = 1'b0;
        cycle();
        cycle();
    endtask

    int sol [7] = '{2, 0, 1, 2, 3, 0, 2};

    initial begin
        cycle();
        cycle();
        cmp_en = 1;
        reset  = 1'b0;
        check("reset_ready", int'(ready_o[0]), 1);
        check("reset_pos", int'({f_o[0], x_o[0], g_o[0], b_o[0]}), 0);
        check("reset_moves", int'(moves_o[0]), 0);

        // Farmer alone leaves fox with goat.
        do_move(0);
        check("unsafe_rej", int'(rej_o[0]), 1);
        check("unsafe_code", int'(code_o[0]), 2);
        check("unsafe_pos", int'({f_o[0], x_o[0], g_o[0], b_o[0]}), 0);
        check("unsafe_moves", int'(moves_o[0]), 0);

        do_reset();
        do_move(2);
        check("goat_pos", int'({f_o[0], x_o[0], g_o[0], b_o[0]}), 4'b1010);
        do_move(0);
        do_move(2);
        check("illegal_rej", int'(rej_o[0]), 1);
        check("illegal_code", int'(code_o[0]), 1);
        check("illegal_pos", int'({f_o[0], x_o[0], g_o[0], b_o[0]}), 4'b0010);

        do_reset();
        foreach (sol[i]) do_move(sol[i]);
        check("solve_pos", int'({f_o[0], x_o[0], g_o[0], b_o[0]}), 4'b1111);
        check("solve_moves", int'(moves_o[0]), 7);
        check("solve_done", int'(done_o[0]), 1);
        check("solve_ready", int'(ready_o[0]), 0);
        check("small_budget_exh", int'(exh_o[1]), 1);
        check("small_budget_pos", int'({f_o[1], x_o[1], g_o[1], b_o[1]}), 4'b0100);

        do_reset();
        for (int i = 0; i < 4; i++) do_move(2);
        check("exh_moves", int'(moves_o[1]), 4);
        check("exh_flag", int'(exh_o[1]), 1);
        check("exh_done", int'(done_o[1]), 0);
        check("exh_ready", int'(ready_o[1]), 0);

        // Reset while the accepted move sits in CHECK.
        do_reset();
        move_valid = 1'b1;
        move_sel   = 2'd2;
        cycle();
        move_valid = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("midrst_pos", int'({f_o[0], x_o[0], g_o[0], b_o[0]}), 0);
        check("midrst_moves", int'(moves_o[0]), 0);
        check("midrst_rej", int'(rej_o[0]), 0);
        check("midrst_ready", int'(ready_o[0]), 1);
        repeat (3) cycle();
        check("midrst_discard", int'({f_o[0], x_o[0], g_o[0], b_o[0]}), 0);

`ifdef FARMER_UNDO_EN
        do_reset();
        do_move(2);
        undo_req = 1'b1;
        cycle();
        undo_req = 1'b0;
        check("undo_pos", int'({f_o[0], x_o[0], g_o[0], b_o[0]}), 0);
        check("undo_moves", int'(moves_o[0]), 0);
        undo_req = 1'b1;
        cycle();
        undo_req = 1'b0;
        check("undo2_rej", int'(rej_o[0]), 1);
        check("undo2_code", int'(code_o[0]), 3);
`endif

        do_reset();
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            move_valid = ($urandom_range(0, 2) != 0);
            move_sel   = 2'($urandom_range(0, 3));
`ifdef FARMER_UNDO_EN
            undo_req   = ($urandom_range(0, 3) == 0);
`endif
            if (done_o[0] && exh_o[1] && $urandom_range(0, 3) == 0) reset = 1'b1;
            cycle();
        end
        reset      = 1'b0;
        move_valid = 1'b0;
        cycle();
        cmp_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
